// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared types for the bit-serial adder datapath
// Purpose: common width default and serializer state encoding, reused by the
//          serializer, the bit-serial adder and the downstream deserializer.
// Ports:   none (package).
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in serial-out shift register, LSB first
// Purpose: holds one operand and presents its current LSB; a load captures a
//          new parallel word, a shift moves every bit one place towards bit 0
//          and fills the MSB with zero. Load wins over shift.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous active-high reset, clears the register
//   load   in  1      capture d at the next edge
//   shift  in  1      right-shift at the next edge (ignored while load=1)
//   d      in  WIDTH  parallel load data
//   q0     out 1      current bit 0 of the register
module piso_shift_reg
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = d;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q0 = sh_q[0];

endmodule

// File: rtl/bit_serial_operand_serializer.sv
// rtl/bit_serial_operand_serializer.sv - feeds operand pairs LSB-first into a bit-serial adder
// Purpose: accepts a pair of WIDTH-bit operands over valid/ready, emits one bit
//          pair per clock starting the cycle after the accept, and drives the
//          adder's carry clear so every word starts with a zero carry. Words can
//          run back to back with no idle cycle between them.
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset
//   in_valid   in  1      operand pair on in_a/in_b is valid
//   in_ready   out 1      an operand pair is accepted this cycle if in_valid=1
//   in_a       in  WIDTH  operand A
//   in_b       in  WIDTH  operand B
//   bit_a      out 1      serial bit of A
//   bit_b      out 1      serial bit of B
//   bit_valid  out 1      bit_a/bit_b are live this cycle
//   bit_first  out 1      current bit is bit 0 of a word
//   bit_last   out 1      current bit is bit WIDTH-1 of a word
//   carry_clr  out 1      adder carry reset; clears the carry at the next edge
module bit_serial_operand_serializer
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_valid,
  output logic             bit_first,
  output logic             bit_last,
  output logic             carry_clr
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic in_shift;
  logic at_last;
  logic accept;
  logic load_en;
  logic shift_en;
  logic sh_a0;
  logic sh_b0;

  assign in_shift = (state_q == SHIFT);
  assign at_last  = in_shift && (cnt_q == LAST_CNT);
  // The last bit of a word frees the register pair, so a new word can be
  // loaded on the same edge that retires the old one.
  assign in_ready = (state_q == IDLE) || at_last;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (in_shift) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_en  = accept;
  assign shift_en = in_shift && !accept;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sh_a (
    .clk  (clk),
    .reset(reset),
    .load (load_en),
    .shift(shift_en),
    .d    (in_a),
    .q0   (sh_a0)
  );

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_sh_b (
    .clk  (clk),
    .reset(reset),
    .load (load_en),
    .shift(shift_en),
    .d    (in_b),
    .q0   (sh_b0)
  );

  // Bits are forced low outside SHIFT so an idle adder sees 0+0.
  assign bit_valid = in_shift;
  assign bit_a     = in_shift && sh_a0;
  assign bit_b     = in_shift && sh_b0;
  assign bit_first = in_shift && (cnt_q == '0);
  assign bit_last  = at_last;
  // Held high whenever the next cycle could be bit 0 of a word: while idle, and
  // during the last bit (which also drops the final carry-out of the word).
  assign carry_clr = (state_q == IDLE) || at_last;

endmodule
